ball_axis_ctrl: RTL and testbench

- Per-axis ball motion controller; sits directly upstream of the 2-stage bounded-position pipeline (nextBoundedPosPipelined) and consumes its clamped result.
- Holds the axis position and signed velocity. On each frame tick it issues one request to the pipeline, waits out the latency, and commits the clamped position.
- Detects wall contact and reflects the velocity. One instance per axis (X, Y) in the pong core.

---
 rtl/ball_axis_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ball_axis_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/ball_axis_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ball_axis_ctrl
//  Purpose  : Per-axis ball motion controller. Holds the committed position
//             and signed velocity of one axis. Each frame tick issues one
//             request to the downstream 2-stage bounded-position pipeline,
//             waits out its latency, commits the clamped position, and
//             reflects the velocity on wall contact.
//  Ports    : CLK, RST (sync, active-high)
//             tick, serve                     - control strobes
//             initPos, initSpeed              - values loaded on serve
//             lowerBound, upperBound          - clamp limits
//             dir, speed, boundary, currentPos - request to pipeline
//             boundedNextPos                  - clamped result from pipeline
//             pos, busy, done, hitUpper, hitLower, overrun - status
//  Options  : BALL_AXIS_SPEEDUP_EN - each bounce increases the velocity
//             magnitude by 1, saturating at MAX_SPEED.
//  Revision : 1.0 - initial release
// ============================================================================
module ball_axis_ctrl #(
  parameter int POS_LOG_SIZE = 10,
  parameter int MAX_SPEED    = 15
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    tick,
  input  logic                    serve,
  input  logic [POS_LOG_SIZE-1:0] initPos,
  input  logic [4:0]              initSpeed,
  input  logic [POS_LOG_SIZE-1:0] lowerBound,
  input  logic [POS_LOG_SIZE-1:0] upperBound,
  output logic                    dir,
  output logic [4:0]              speed,
  output logic [POS_LOG_SIZE-1:0] boundary,
  output logic [POS_LOG_SIZE-1:0] currentPos,
  input  logic [POS_LOG_SIZE-1:0] boundedNextPos,
  output logic [POS_LOG_SIZE-1:0] pos,
  output logic                    busy,
  output logic                    done,
  output logic                    hitUpper,
  output logic                    hitLower,
  output logic                    overrun
);

`ifdef BALL_AXIS_SPEEDUP_EN
  localparam bit C_SPEEDUP_ON = 1'b1;
`else
  localparam bit C_SPEEDUP_ON = 1'b0;
`endif

  // Without speed-up the ceiling of 15 only matters for -16, whose
  // reflection is not representable and becomes +15.
  localparam logic [5:0] C_SPEED_CEIL = C_SPEEDUP_ON ? 6'(MAX_SPEED) : 6'd15;
  localparam logic [5:0] C_SPEED_STEP = C_SPEEDUP_ON ? 6'd1 : 6'd0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_WAIT1  = 3'd2,
    ST_WAIT2  = 3'd3,
    ST_COMMIT = 3'd4
  } state_t;

  state_t                    state_q, state_d;
  logic [POS_LOG_SIZE-1:0]   pos_q, pos_d;
  logic [4:0]                speed_q, speed_d;
  logic                      overrun_q, overrun_d;
  logic                      done_q, done_d;
  logic                      hit_upper_q, hit_upper_d;
  logic                      hit_lower_q, hit_lower_d;

  logic                      w_dir;
  logic [POS_LOG_SIZE-1:0]   w_boundary;
  logic                      w_busy;
  logic                      w_hit;
  logic [5:0]                w_speed_ext;
  logic [5:0]                w_mag;
  logic [5:0]                w_mag_new;
  logic [4:0]                w_mag_sat;
  logic [4:0]                w_refl_speed;

  assign w_dir      = ~speed_q[4];
  assign w_boundary = w_dir ? upperBound : lowerBound;
  assign w_busy     = (state_q != ST_IDLE);
  assign w_hit      = (boundedNextPos == w_boundary) && (speed_q != 5'd0);

  // Reflection: work on the magnitude in 6 bits so that -16 has a
  // representable magnitude, then saturate and apply the opposite sign.
  assign w_speed_ext  = {speed_q[4], speed_q};
  assign w_mag        = speed_q[4] ? (6'd0 - w_speed_ext) : w_speed_ext;
  assign w_mag_new    = w_mag + C_SPEED_STEP;
  assign w_mag_sat    = (w_mag_new > C_SPEED_CEIL) ? C_SPEED_CEIL[4:0] : w_mag_new[4:0];
  assign w_refl_speed = speed_q[4] ? w_mag_sat : (5'd0 - w_mag_sat);

  always_comb begin
    state_d     = state_q;
    pos_d       = pos_q;
    speed_d     = speed_q;
    overrun_d   = overrun_q;
    done_d      = 1'b0;
    hit_upper_d = 1'b0;
    hit_lower_d = 1'b0;

    if (serve) begin
      // Serve aborts any update in flight; a coincident tick is dropped.
      pos_d     = initPos;
      speed_d   = initSpeed;
      state_d   = ST_IDLE;
      overrun_d = 1'b0;
    end else begin
      if (tick && w_busy) begin
        overrun_d = 1'b1;
      end
      case (state_q)
        ST_IDLE:   if (tick) state_d = ST_ISSUE;
        ST_ISSUE:  state_d = ST_WAIT1;
        ST_WAIT1:  state_d = ST_WAIT2;
        ST_WAIT2:  state_d = ST_COMMIT;
        ST_COMMIT: begin
          pos_d   = boundedNextPos;
          done_d  = 1'b1;
          state_d = ST_IDLE;
          if (w_hit) begin
            speed_d     = w_refl_speed;
            hit_upper_d = w_dir;
            hit_lower_d = ~w_dir;
          end
        end
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      pos_q       <= '0;
      speed_q     <= '0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
      hit_upper_q <= 1'b0;
      hit_lower_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pos_q       <= pos_d;
      speed_q     <= speed_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
      hit_upper_q <= hit_upper_d;
      hit_lower_q <= hit_lower_d;
    end
  end

  assign dir        = w_dir;
  assign speed      = speed_q;
  assign boundary   = w_boundary;
  assign currentPos = pos_q;
  assign pos        = pos_q;
  assign busy       = w_busy;
  assign done       = done_q;
  assign hitUpper   = hit_upper_q;
  assign hitLower   = hit_lower_q;
  assign overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ball_axis_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ball_axis_ctrl
//  Purpose  : Directed self-checking bench for ball_axis_ctrl. Includes a
//             behavioural 2-stage bounded-position pipeline feeding
//             boundedNextPos.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ball_axis_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] initPos = '0;
  logic [4:0] initSpeed = '0;
  logic [9:0] lowerBound = 10'd8;
  logic [9:0] upperBound = 10'd600;
  logic       dir;
  logic [4:0] speed;
  logic [9:0] boundary;
  logic [9:0] currentPos;
  logic [9:0] boundedNextPos;
  logic [9:0] pos;
  logic       busy, done, hitUpper, hitLower, overrun;

  int checks = 0;
  int errors = 0;

  logic [9:0] pipe1 = '0;
  logic [9:0] pipe2 = '0;

  ball_axis_ctrl #(.POS_LOG_SIZE(10), .MAX_SPEED(15)) dut (
    .CLK(CLK), .RST(RST), .tick(tick), .serve(serve),
    .initPos(initPos), .initSpeed(initSpeed),
    .lowerBound(lowerBound), .upperBound(upperBound),
    .dir(dir), .speed(speed), .boundary(boundary), .currentPos(currentPos),
    .boundedNextPos(boundedNextPos), .pos(pos), .busy(busy), .done(done),
    .hitUpper(hitUpper), .hitLower(hitLower), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  function automatic logic [9:0] clamp_model(input logic [9:0] cur, input logic [4:0] spd,
                                             input logic d, input logic [9:0] bnd);
    int n;
    n = int'(cur) + int'($signed(spd));
    if (d) begin
      if (n >= int'(bnd)) return bnd;
    end else begin
      if (n <= int'(bnd)) return bnd;
    end
    return n[9:0];
  endfunction

  // Downstream pipeline: captures at every edge, result 2 edges later.
  always @(posedge CLK) begin
    pipe1 <= clamp_model(currentPos, speed, dir, boundary);
    pipe2 <= pipe1;
  end
  assign boundedNextPos = pipe2;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_serve(input logic [9:0] p, input logic [4:0] s);
    initPos = p; initSpeed = s; serve = 1'b1;
    step();
    serve = 1'b0;
  endtask

  // Pulses tick in IDLE and waits (bounded) for done.
  task automatic run_update(output int lat, output logic hu, output logic hl,
                            output logic idir, output logic [9:0] ibnd);
    tick = 1'b1;
    step();
    tick = 1'b0;
    idir = dir;
    ibnd = boundary;
    lat = 0;
    while (!done && lat < 20) begin
      step();
      lat++;
    end
    hu = hitUpper;
    hl = hitLower;
  endtask

  task automatic test_reset();
    int lat; logic hu, hl, idir; logic [9:0] ibnd;
    RST = 1'b1;
    step(); step();
    checks++; if (pos !== 10'd0) begin errors++; $display("FAIL reset_pos got %0d want 0", pos); end
    checks++; if (speed !== 5'd0) begin errors++; $display("FAIL reset_speed got %0d want 0", speed); end
    checks++; if ({busy, done, hitUpper, hitLower, overrun} !== 5'b0)
      begin errors++; $display("FAIL reset_flags got %b want 00000", {busy, done, hitUpper, hitLower, overrun}); end
    checks++; if (dir !== 1'b1 || boundary !== 10'd600)
      begin errors++; $display("FAIL reset_dir_bnd got %b/%0d want 1/600", dir, boundary); end
    RST = 1'b0;
    run_update(lat, hu, hl, idir, ibnd);
    checks++; if (lat !== 4) begin errors++; $display("FAIL idle_latency got %0d want 4", lat); end
    checks++; if (pos !== 10'd0 || hu !== 1'b0 || hl !== 1'b0)
      begin errors++; $display("FAIL idle_update got pos=%0d hit=%b%b want pos=0 hit=00", pos, hu, hl); end
  endtask

  task automatic test_free_motion();
    int lat; logic hu, hl, idir; logic [9:0] ibnd;
    lowerBound = 10'd8; upperBound = 10'd600;
    do_serve(10'd100, 5'd5);
    checks++; if (pos !== 10'd100 || speed !== 5'd5)
      begin errors++; $display("FAIL serve_load got %0d/%0d want 100/5", pos, speed); end
    run_update(lat, hu, hl, idir, ibnd);
    checks++; if (idir !== 1'b1 || ibnd !== 10'd600)
      begin errors++; $display("FAIL free_request got %b/%0d want 1/600", idir, ibnd); end
    checks++; if (lat !== 4 || pos !== 10'd105 || hu !== 1'b0 || hl !== 1'b0)
      begin errors++; $display("FAIL free_first got lat=%0d pos=%0d hit=%b%b want 4/105/00", lat, pos, hu, hl); end
    run_update(lat, hu, hl, idir, ibnd);
    checks++; if (pos !== 10'd110)
      begin errors++; $display("FAIL free_second got %0d want 110", pos); end
  endtask

  task automatic test_upper_bounce();
    int lat; logic hu, hl, idir; logic [9:0] ibnd;
    logic [4:0] exp_speed; logic [9:0] exp_pos;
`ifdef BALL_AXIS_SPEEDUP_EN
    exp_speed = 5'h1B; exp_pos = 10'd595;
`else
    exp_speed = 5'h1C; exp_pos = 10'd596;
`endif
    do_serve(10'd598, 5'd4);
    run_update(lat, hu, hl, idir, ibnd);
    checks++; if (pos !== 10'd600 || hu !== 1'b1 || hl !== 1'b0)
      begin errors++; $display("FAIL upper_hit got pos=%0d hit=%b%b want 600/10", pos, hu, hl); end
    checks++; if (speed !== exp_speed)
      begin errors++; $display("FAIL upper_reflect got %h want %h", speed, exp_speed); end
    run_update(lat, hu, hl, idir, ibnd);
    checks++; if (idir !== 1'b0 || ibnd !== 10'd8)
      begin errors++; $display("FAIL upper_return_req got %b/%0d want 0/8", idir, ibnd); end
    checks++; if (pos !== exp_pos || hu !== 1'b0 || hl !== 1'b0)
      begin errors++; $display("FAIL upper_return got pos=%0d hit=%b%b want %0d/00", pos, hu, hl, exp_pos); end
  endtask

  task automatic test_lower_bounce();
    int lat; logic hu, hl, idir; logic [9:0] ibnd;
    logic [4:0] exp_speed;
`ifdef BALL_AXIS_SPEEDUP_EN
    exp_speed = 5'd6;
`else
    exp_speed = 5'd5;
`endif
    do_serve(10'd10, 5'h10);
    run_update(lat, hu, hl, idir, ibnd);
    checks++; if (pos !== 10'd8 || hl !== 1'b1 || hu !== 1'b0)
      begin errors++; $display("FAIL lower_m16_hit got pos=%0d hit=%b%b want 8/01", pos, hu, hl); end
    checks++; if (speed !== 5'd15)
      begin errors++; $display("FAIL lower_m16_speed got %h want 0f", speed); end
    do_serve(10'd13, 5'h1B);
    run_update(lat, hu, hl, idir, ibnd);
    checks++; if (pos !== 10'd8 || hl !== 1'b1 || hu !== 1'b0)
      begin errors++; $display("FAIL lower_exact_hit got pos=%0d hit=%b%b want 8/01", pos, hu, hl); end
    checks++; if (speed !== exp_speed)
      begin errors++; $display("FAIL lower_exact_speed got %h want %h", speed, exp_speed); end
  endtask

  task automatic test_overrun_abort();
    int dones;
    do_serve(10'd200, 5'd1);
    tick = 1'b1; step(); tick = 1'b0;
    step();
    tick = 1'b1; step(); tick = 1'b0;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      step();
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL overrun_dones got %0d want 1", dones); end
    checks++; if (overrun !== 1'b1 || pos !== 10'd201 || busy !== 1'b0)
      begin errors++; $display("FAIL overrun_state got ovr=%b pos=%0d busy=%b want 1/201/0", overrun, pos, busy); end
    // Abort from WAIT2 with a serve
    tick = 1'b1; step(); tick = 1'b0;
    step(); step();
    initPos = 10'd50; initSpeed = 5'd3; serve = 1'b1;
    step();
    serve = 1'b0;
    checks++; if (busy !== 1'b0 || pos !== 10'd50 || speed !== 5'd3 || overrun !== 1'b0)
      begin errors++; $display("FAIL abort_state got busy=%b pos=%0d spd=%0d ovr=%b want 0/50/3/0", busy, pos, speed, overrun); end
    dones = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || hitUpper || hitLower) dones++;
      step();
    end
    checks++; if (dones !== 0 || pos !== 10'd50)
      begin errors++; $display("FAIL abort_no_done got %0d pulses pos=%0d want 0/50", dones, pos); end
    // Tick coincident with serve is dropped without overrun
    initPos = 10'd60; initSpeed = 5'd2; serve = 1'b1; tick = 1'b1;
    step();
    serve = 1'b0; tick = 1'b0;
    checks++; if (busy !== 1'b0 || overrun !== 1'b0 || pos !== 10'd60)
      begin errors++; $display("FAIL serve_tick got busy=%b ovr=%b pos=%0d want 0/0/60", busy, overrun, pos); end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_serve(10'd400, 5'd7);
    tick = 1'b1; step(); tick = 1'b0;
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    checks++; if (busy !== 1'b0 || pos !== 10'd0 || speed !== 5'd0)
      begin errors++; $display("FAIL rst_mid_state got busy=%b pos=%0d spd=%0d want 0/0/0", busy, pos, speed); end
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      if (done || hitUpper || hitLower) pulses++;
      step();
    end
    checks++; if (pulses !== 0 || pos !== 10'd0)
      begin errors++; $display("FAIL rst_mid_pulses got %0d pos=%0d want 0/0", pulses, pos); end
  endtask

  initial begin
    test_reset();
    test_free_motion();
    test_upper_bounce();
    test_lower_bounce();
    test_overrun_abort();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
